// File: rtl/nibble_payload_inserter.sv
// Buffers payload words in a FIFO and splices them nibble by nibble into the
// user-data slots of a MAC nibble stream, with frame request/accounting logic.
module nibble_payload_inserter #(
  parameter int NIB_W         = 4,
  parameter int DATA_W        = 8,
  parameter int DEPTH_LOG2    = 12,
  parameter int FILLED_THRESH = 1024,
  parameter int LSB_FIRST     = 1,
  parameter logic [NIB_W-1:0] PAD = '0
) (
  input  logic                  eth_clk,
  input  logic                  rst_n,
  input  logic                  enqueue,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic [NIB_W-1:0]      nibble,
  input  logic                  nibble_user_data,
  input  logic                  nibble_valid,
  output logic [NIB_W-1:0]      with_usr,
  output logic                  with_usr_valid,
  output logic                  start_send,
  output logic                  frame_done,
  output logic [15:0]           frame_words,
  output logic                  overflow,
  output logic                  underrun,
  input  logic                  clr_flags
);

  localparam int SLOTS = DATA_W / NIB_W;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int KW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [KW-1:0]       K_LAST     = KW'(SLOTS - 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_THRESH = (DEPTH_LOG2 + 1)'(FILLED_THRESH);
  localparam logic [DATA_W-1:0]   PAD_WORD   = {SLOTS{PAD}};

  typedef enum logic [1:0] {IDLE, ARMED, FRAME} state_t;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0]     hold;
  logic [KW-1:0]         slot;
  logic [NIB_W-1:0]      nib_p0;
  logic                  usr_p0, vld_p0;
  logic [KW-1:0]         slot_p0;
  logic [15:0]           frame_cnt;
  state_t                state, state_nxt;
  logic                  frame_end;

  logic user_in, empty, load, do_pop, do_pad, do_push;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign user_in = nibble_valid & nibble_user_data;
  assign load    = user_in && (slot == '0);
  assign do_pop  = load && !empty;
  assign do_pad  = load && empty;
  assign do_push = enqueue && !full;

  function automatic logic [NIB_W-1:0] pick_nibble(input logic [DATA_W-1:0] w,
                                                   input logic [KW-1:0] k);
    int idx;
    idx = (LSB_FIRST != 0) ? int'(k) : (SLOTS - 1 - int'(k));
    return w[idx*NIB_W +: NIB_W];
  endfunction

  always_ff @(posedge eth_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge eth_clk) begin
    if (load) hold <= do_pop ? mem[rd_ptr] : PAD_WORD;
  end

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Stage p0: capture stream nibble and slot position; hold is loaded here.
  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot    <= '0;
      nib_p0  <= '0;
      usr_p0  <= 1'b0;
      vld_p0  <= 1'b0;
      slot_p0 <= '0;
    end else begin
      if (!user_in)            slot <= '0;
      else if (slot == K_LAST) slot <= '0;
      else                     slot <= slot + 1'b1;
      nib_p0  <= nibble;
      usr_p0  <= user_in;
      vld_p0  <= nibble_valid;
      slot_p0 <= slot;
    end
  end

  // Stage p1: select payload nibble or pass-through nibble.
  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      with_usr       <= '0;
      with_usr_valid <= 1'b0;
    end else begin
      with_usr       <= usr_p0 ? pick_nibble(hold, slot_p0) : nib_p0;
      with_usr_valid <= vld_p0;
    end
  end

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overflow <= (enqueue & full) | (overflow & ~clr_flags);
      underrun <= do_pad | (underrun & ~clr_flags);
    end
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (nibble_valid)                               state_nxt = FRAME;
        else if (!with_usr_valid && level >= LVL_THRESH) state_nxt = ARMED;
      end
      ARMED: if (nibble_valid) state_nxt = FRAME;
      FRAME: begin
        if (!nibble_valid) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_send  <= 1'b0;
      frame_done  <= 1'b0;
      frame_words <= '0;
      frame_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      start_send <= (state_nxt == ARMED);
      frame_done <= frame_end;
      if (frame_end) begin
        frame_words <= frame_cnt;
        frame_cnt   <= '0;
      end else if (do_pop && frame_cnt != 16'hFFFF) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_payload_inserter.sv
// Randomized bench for nibble_payload_inserter: two instances (LSB-first/PAD=0
// and MSB-first/PAD=A) share stimulus and are compared to a queue-based model.
module tb_nibble_payload_inserter;

  logic       clk = 1'b0;
  logic       rst_n, enqueue, clr_flags, nibble_valid, nibble_user_data;
  logic [7:0] wdata;
  logic [3:0] nibble;

  logic        a_full, a_wuv, a_ss, a_fd, a_ovf, a_und;
  logic [12:0] a_level;
  logic [3:0]  a_wu;
  logic [15:0] a_fw;
  logic        b_full, b_wuv, b_ss, b_fd, b_ovf, b_und;
  logic [12:0] b_level;
  logic [3:0]  b_wu;
  logic [15:0] b_fw;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_payload_inserter u_lsb (
    .eth_clk(clk), .rst_n(rst_n), .enqueue(enqueue), .wdata(wdata),
    .full(a_full), .level(a_level), .nibble(nibble),
    .nibble_user_data(nibble_user_data), .nibble_valid(nibble_valid),
    .with_usr(a_wu), .with_usr_valid(a_wuv), .start_send(a_ss),
    .frame_done(a_fd), .frame_words(a_fw), .overflow(a_ovf),
    .underrun(a_und), .clr_flags(clr_flags)
  );

  nibble_payload_inserter #(.LSB_FIRST(0), .PAD(4'hA)) u_msb (
    .eth_clk(clk), .rst_n(rst_n), .enqueue(enqueue), .wdata(wdata),
    .full(b_full), .level(b_level), .nibble(nibble),
    .nibble_user_data(nibble_user_data), .nibble_valid(nibble_valid),
    .with_usr(b_wu), .with_usr_valid(b_wuv), .start_send(b_ss),
    .frame_done(b_fd), .frame_words(b_fw), .overflow(b_ovf),
    .underrun(b_und), .clr_flags(clr_flags)
  );

  // Reference model state
  byte unsigned q[$];
  int           run_pos, m_cnt;
  logic [7:0]   hold_a, hold_b;
  bit           m_ovf, m_und, m_armed, m_inframe, m_done;
  logic [15:0]  m_words;
  logic [3:0]   exp_a, pend_a, exp_b, pend_b;
  bit           exp_v, pend_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    run_pos = 0; m_cnt = 0;
    m_ovf = 0; m_und = 0; m_armed = 0; m_inframe = 0; m_done = 0;
    m_words = '0;
    exp_a = '0; pend_a = '0; exp_b = '0; pend_b = '0;
    exp_v = 0; pend_v = 0;
  endtask

  task automatic model_edge();
    int  lvl0, k;
    bit  wv0, usr, set_ovf, set_und;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lvl0 = q.size();
    wv0  = exp_v;
    usr  = nibble_valid && nibble_user_data;
    set_ovf = 0; set_und = 0;
    exp_a = pend_a; exp_b = pend_b; exp_v = pend_v;
    pend_v = nibble_valid;
    if (usr) begin
      k = run_pos % 2;
      if (k == 0) begin
        if (lvl0 > 0) begin
          hold_a = q.pop_front();
          hold_b = hold_a;
          m_cnt++;
        end else begin
          hold_a = 8'h00;
          hold_b = 8'hAA;
          set_und = 1;
        end
      end
      pend_a = (k == 0) ? hold_a[3:0] : hold_a[7:4];
      pend_b = (k == 0) ? hold_b[7:4] : hold_b[3:0];
      run_pos++;
    end else begin
      run_pos = 0;
      pend_a = nibble;
      pend_b = nibble;
    end
    if (enqueue) begin
      if (lvl0 == 4096) set_ovf = 1;
      else q.push_back(wdata);
    end
    m_ovf = set_ovf || (m_ovf && !clr_flags);
    m_und = set_und || (m_und && !clr_flags);
    m_done = 0;
    if (m_inframe) begin
      if (!nibble_valid) begin
        m_inframe = 0;
        m_done = 1;
        m_words = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        m_cnt = 0;
      end
    end else if (m_armed) begin
      if (nibble_valid) begin
        m_armed = 0;
        m_inframe = 1;
      end
    end else if (nibble_valid) begin
      m_inframe = 1;
    end else if (!wv0 && lvl0 >= 1024) begin
      m_armed = 1;
    end
  endtask

  task automatic check_all();
    check("with_usr_lsb", 32'(a_wu),  32'(exp_a));
    check("with_usr_msb", 32'(b_wu),  32'(exp_b));
    check("wu_valid_lsb", 32'(a_wuv), 32'(exp_v));
    check("wu_valid_msb", 32'(b_wuv), 32'(exp_v));
    check("level_lsb",    32'(a_level), 32'(q.size()));
    check("level_msb",    32'(b_level), 32'(q.size()));
    check("full_lsb",     32'(a_full), 32'(q.size() == 4096));
    check("full_msb",     32'(b_full), 32'(q.size() == 4096));
    check("start_lsb",    32'(a_ss),  32'(m_armed));
    check("start_msb",    32'(b_ss),  32'(m_armed));
    check("fdone_lsb",    32'(a_fd),  32'(m_done));
    check("fdone_msb",    32'(b_fd),  32'(m_done));
    check("fwords_lsb",   32'(a_fw),  32'(m_words));
    check("fwords_msb",   32'(b_fw),  32'(m_words));
    check("ovf_lsb",      32'(a_ovf), 32'(m_ovf));
    check("ovf_msb",      32'(b_ovf), 32'(m_ovf));
    check("und_lsb",      32'(a_und), 32'(m_und));
    check("und_msb",      32'(b_und), 32'(m_und));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    enqueue = 0; clr_flags = 0; nibble_valid = 0; nibble_user_data = 0;
    wdata = '0; nibble = '0;
  endtask

  task automatic user_run(input int n);
    nibble_valid = 1;
    for (int i = 0; i < n; i++) begin
      nibble_user_data = 1;
      nibble = 4'($urandom);
      tick();
    end
    nibble_user_data = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    check_all();
    repeat (2) tick();
    rst_n = 1;

    // Queue 0x00..0x3F, then a 4-nibble user run.
    for (int i = 0; i < 64; i++) begin
      enqueue = 1;
      wdata = 8'(i);
      tick();
    end
    enqueue = 0;
    user_run(4);
    nibble_valid = 0;
    repeat (3) tick();
    check("level_after_run", 32'(a_level), 32'd62);
    check("no_underrun", 32'(a_und), 32'd0);

    // Random bursts with occasional enqueue, stray user flags and clears.
    for (int i = 0; i < 1500; i++) begin
      enqueue   = ($urandom_range(0, 7) == 0);
      wdata     = 8'($urandom);
      clr_flags = ($urandom_range(0, 49) == 0);
      nibble    = 4'($urandom);
      if (nibble_valid) nibble_valid = ($urandom_range(0, 19) != 0);
      else              nibble_valid = ($urandom_range(0, 9) == 0);
      nibble_user_data = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // Drain until empty so PAD words are emitted, then clear the flag.
    user_run(200);
    nibble_valid = 0;
    repeat (3) tick();
    check("underrun_set", 32'(a_und), 32'd1);
    clr_flags = 1;
    tick();
    clr_flags = 0;
    tick();
    check("underrun_clr", 32'(a_und), 32'd0);

    // Fill beyond capacity with the stream idle.
    for (int i = 0; i < 4200; i++) begin
      enqueue = 1;
      wdata = 8'($urandom);
      tick();
    end
    check("fill_full",  32'(a_full),  32'd1);
    check("fill_level", 32'(a_level), 32'd4096);
    check("fill_ovf",   32'(a_ovf),   32'd1);
    check("fill_start", 32'(a_ss),    32'd1);
    clr_flags = 1;
    tick();
    enqueue = 0;
    tick();
    clr_flags = 0;
    tick();
    check("ovf_cleared", 32'(a_ovf), 32'd0);

    // Ten user nibbles make a five-word frame.
    user_run(10);
    nibble_valid = 0;
    tick();
    check("frame_done_pulse", 32'(a_fd), 32'd1);
    check("frame_words_10",   32'(a_fw), 32'd5);
    repeat (4) tick();

    // Runs ending mid-word, then a reset in the middle of a frame.
    user_run(3);
    nibble_valid = 1;
    tick();
    user_run(3);
    nibble_valid = 1;
    nibble_user_data = 1;
    tick();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    repeat (2) tick();
    rst_n = 1;
    idle_inputs();
    repeat (4) tick();
    check("post_reset_no_done", 32'(a_fd), 32'd0);

    // Random traffic after reset.
    for (int i = 0; i < 400; i++) begin
      enqueue   = ($urandom_range(0, 1) == 0);
      wdata     = 8'($urandom);
      clr_flags = ($urandom_range(0, 29) == 0);
      nibble    = 4'($urandom);
      if (nibble_valid) nibble_valid = ($urandom_range(0, 9) != 0);
      else              nibble_valid = ($urandom_range(0, 4) == 0);
      nibble_user_data = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_payload_inserter.md
Name: nibble_payload_inserter

Overview:
- Single-clock, parametrised successor to the encoder-to-Ethernet bridge.
- Buffers payload words in an internal synchronous FIFO and splices them, nibble by nibble, into the user-data slots of the MAC's nibble stream.
- Non-user nibbles pass through unchanged; requests a frame once enough payload is buffered.
- Adds underrun padding, overflow/underrun flags, selectable nibble order and per-frame word counts; sits between the capture/encoder path (already in eth_clk) and the MII TX nibble generator.

Parameters:
NIB_W, 4, nibble (stream lane) width in bits
DATA_W, 8, payload word width; must be an integer multiple of NIB_W (SLOTS = DATA_W/NIB_W)
DEPTH_LOG2, 12, FIFO depth = 2**DEPTH_LOG2 words
FILLED_THRESH, 1024, level at or above which a frame is requested
LSB_FIRST, 1, 1: emit the least-significant nibble of a word first; 0: most-significant first
PAD, 0, NIB_W-bit value emitted in user slots when the FIFO is empty

Ports:
eth_clk  in  1  sole clock
rst_n  in  1  asynchronous, active-low reset
enqueue  in  1  write strobe for wdata
wdata  in  DATA_W  payload word
full  out  1  FIFO full (level == 2**DEPTH_LOG2)
level  out  DEPTH_LOG2+1  current FIFO occupancy
nibble  in  NIB_W  MAC nibble stream
nibble_user_data  in  1  current nibble is a payload slot
nibble_valid  in  1  frame active
with_usr  out  NIB_W  stream with payload inserted
with_usr_valid  out  1  nibble_valid delayed 2 cycles
start_send  out  1  frame request to MAC
frame_done  out  1  one-cycle pulse at frame end
frame_words  out  16  words popped in the last completed frame (saturates at 0xFFFF)
overflow  out  1  sticky: enqueue dropped because the FIFO was full
underrun  out  1  sticky: PAD word emitted
clr_flags  in  1  synchronous clear of overflow/underrun

Behaviour:
- Reset (rst_n low, asynchronous): FIFO emptied (level=0), full=0, with_usr=0, with_usr_valid=0, start_send=0, frame_done=0, frame_words=0, overflow=0, underrun=0, slot counter=0, FSM=IDLE. Reset mid-frame aborts the frame with no frame_done.
- Write: enqueue & !full stores wdata. enqueue & full drops the word and sets overflow. full is evaluated before any same-cycle pop, so a write at full is dropped even if a pop occurs.
- Stream latency: exactly 2 cycles from input to with_usr/with_usr_valid, for every nibble.
- Non-user nibble (nibble_user_data=0): with_usr = nibble (delayed 2); slot counter forced to 0.
- User nibble, slot counter k (0..SLOTS-1), incremented per user nibble and wrapping SLOTS-1 -> 0:
  - k==0, FIFO non-empty: pop one word into a hold register; frame word count +1.
  - k==0, FIFO empty: no pop; hold = PAD replicated to fill the word; underrun set.
  - Output nibble = hold[k*NIB_W +: NIB_W] if LSB_FIRST, else hold[(SLOTS-1-k)*NIB_W +: NIB_W].
- Run of user slots ending mid-word: remaining nibbles are discarded; the next run starts at k=0.
- nibble_user_data while nibble_valid=0 is ignored: treated as non-user, no pop.
- Simultaneous enqueue and pop below full: both occur; level unchanged.
- Frame FSM:
  - IDLE -> ARMED when with_usr_valid==0 and level >= FILLED_THRESH; start_send=1 on the cycle after entry.
  - ARMED holds start_send=1 until nibble_valid rises, then -> FRAME with start_send=0 the next cycle.
  - FRAME -> IDLE on nibble_valid falling. The next cycle: frame_done=1 and frame_words = count, then count cleared.
  - A valid burst arriving in IDLE is tracked as FRAME (counted, frame_done issued).
- Flags: clr_flags clears overflow/underrun; a set event in the same cycle wins.

Test Plan:
- Reset, enqueue 0x00..0x3F, then a 4-nibble user run with LSB_FIRST=1 -> with_usr 0,0,1,0 two cycles after the inputs; level 64->62; underrun=0.
- LSB_FIRST=0, word 0xA5 queued, 2 user slots -> with_usr A then 5; non-user nibble 0x7 in the same frame -> 0x7 two cycles later.
- FIFO empty, 2 user slots -> with_usr 0,0 (PAD=0); underrun=1; clr_flags pulse -> 0; no pop, level stays 0.
- Fill to 4096 (DEPTH_LOG2=12), one more enqueue -> dropped, overflow=1, level stays 4096, full=1.
- Level reaches 1024 with nibble_valid=0 -> start_send=1 until nibble_valid rises; a frame with 10 user nibbles -> frame_done pulse with frame_words=5.
- User run of 3 nibbles (DATA_W=8) -> 2 words popped, last nibble of word 2 discarded; next run restarts at k=0; rst_n low mid-frame -> all outputs 0 immediately, no frame_done.
